// File: rtl/clock_hms_setter_if.sv
// Set-side bundle between the key/counter environment and clock_hms_setter.
// The master drives the debounced keys and the running time; the slave
// (the setter) returns the commit strobe, the values to load and the edit
// status.
//
// Commit protocol: `set` is a one-cycle strobe with no back-pressure. It acts
// as a valid that the counter must accept in the cycle it is high, with an
// implicit ready of 1. `set_h`/`set_m`/`set_s` are qualified by `set` and keep
// their last committed value afterwards.
interface clock_hms_setter_if;
    logic       key_mode;
    logic       key_inc;
    logic       key_dec;
    logic       key_cancel;
    logic [5:0] cur_h;
    logic [5:0] cur_m;
    logic [5:0] cur_s;
    logic       set;
    logic [5:0] set_h;
    logic [5:0] set_m;
    logic [5:0] set_s;
    logic       editing;
    logic [1:0] field;

    modport master (
        output key_mode, key_inc, key_dec, key_cancel,
        output cur_h, cur_m, cur_s,
        input  set, set_h, set_m, set_s, editing, field
    );

    modport slave (
        input  key_mode, key_inc, key_dec, key_cancel,
        input  cur_h, cur_m, cur_s,
        output set, set_h, set_m, set_s, editing, field
    );
endinterface

// File: rtl/clock_hms_setter.sv
// Button-driven time-setting controller for the h:m:s clock counter.
// The mode key enters edit with a snapshot of the running time and then steps
// through hour, minute and second. Inc and dec change the selected field with
// wrap-around. The last mode press commits the edited time with a one-cycle
// `set` strobe, and cancel abandons the edit.
module clock_hms_setter #(
    parameter int max_h = 12,
    parameter int max_m = 23,
    parameter int max_s = 41
) (
    input  logic                 clk,
    input  logic                 reset,      // asynchronous, active low
    clock_hms_setter_if.slave    bus,
    output logic [1:0]           dbg_state   // raw FSM state, for checkers
);

    // State codes equal the field numbers, so `field` is the state itself.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT_H = 2'd1,
        EDIT_M = 2'd2,
        EDIT_S = 2'd3
    } state_t;

    localparam logic [5:0] MAX_H6 = 6'(max_h);
    localparam logic [5:0] MAX_M6 = 6'(max_m);
    localparam logic [5:0] MAX_S6 = 6'(max_s);
    localparam logic [5:0] TOP_H  = 6'(max_h - 1);
    localparam logic [5:0] TOP_M  = 6'(max_m - 1);
    localparam logic [5:0] TOP_S  = 6'(max_s - 1);

    state_t     state, state_n;
    logic [3:0] key_q;                       // {cancel, dec, inc, mode} history
    logic [5:0] edit_h, edit_m, edit_s;
    logic [5:0] edit_h_n, edit_m_n, edit_s_n;
    logic       set_q, set_n;
    logic [5:0] set_h_q, set_m_q, set_s_q;
    logic [5:0] set_h_n, set_m_n, set_s_n;

    logic [3:0] key_now;
    logic       mode_e, inc_e, dec_e, cancel_e, step_en;

    function automatic logic [5:0] step_up(input logic [5:0] v, input logic [5:0] top);
        return (v == top) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] step_dn(input logic [5:0] v, input logic [5:0] top);
        return (v == 6'd0) ? top : v - 6'd1;
    endfunction

    // Rising-edge detection. The history resets to 1 so that a key held
    // through reset release is not mistaken for a fresh press.
    assign key_now  = {bus.key_cancel, bus.key_dec, bus.key_inc, bus.key_mode};
    assign mode_e   = key_now[0] & ~key_q[0];
    assign inc_e    = key_now[1] & ~key_q[1];
    assign dec_e    = key_now[2] & ~key_q[2];
    assign cancel_e = key_now[3] & ~key_q[3];
    // inc and dec together cancel each other out.
    assign step_en  = inc_e ^ dec_e;

    // Registers: FSM state, key history, edit fields and commit outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            key_q   <= 4'b1111;
            edit_h  <= 6'd0;
            edit_m  <= 6'd0;
            edit_s  <= 6'd0;
            set_q   <= 1'b0;
            set_h_q <= 6'd0;
            set_m_q <= 6'd0;
            set_s_q <= 6'd0;
        end else begin
            state   <= state_n;
            key_q   <= key_now;
            edit_h  <= edit_h_n;
            edit_m  <= edit_m_n;
            edit_s  <= edit_s_n;
            set_q   <= set_n;
            set_h_q <= set_h_n;
            set_m_q <= set_m_n;
            set_s_q <= set_s_n;
        end
    end

    // Next state and edits. Priority is cancel, then mode, then inc/dec, so a
    // step arriving with a mode or cancel press is dropped.
    always_comb begin
        state_n  = state;
        edit_h_n = edit_h;
        edit_m_n = edit_m;
        edit_s_n = edit_s;
        set_n    = 1'b0;
        set_h_n  = set_h_q;
        set_m_n  = set_m_q;
        set_s_n  = set_s_q;
        case (state)
            IDLE: begin
                if (mode_e) begin
                    state_n  = EDIT_H;
                    // Out-of-range snapshot values load 0 so that the edit
                    // fields always stay inside their modulus.
                    edit_h_n = (bus.cur_h >= MAX_H6) ? 6'd0 : bus.cur_h;
                    edit_m_n = (bus.cur_m >= MAX_M6) ? 6'd0 : bus.cur_m;
                    edit_s_n = (bus.cur_s >= MAX_S6) ? 6'd0 : bus.cur_s;
                end
            end
            default: begin
                if (cancel_e) begin
                    state_n  = IDLE;
                    edit_h_n = 6'd0;
                    edit_m_n = 6'd0;
                    edit_s_n = 6'd0;
                end else if (mode_e) begin
                    case (state)
                        EDIT_H:  state_n = EDIT_M;
                        EDIT_M:  state_n = EDIT_S;
                        default: begin
                            state_n = IDLE;
                            set_n   = 1'b1;
                            set_h_n = edit_h;
                            set_m_n = edit_m;
                            set_s_n = edit_s;
                        end
                    endcase
                end else if (step_en) begin
                    case (state)
                        EDIT_H:  edit_h_n = inc_e ? step_up(edit_h, TOP_H) : step_dn(edit_h, TOP_H);
                        EDIT_M:  edit_m_n = inc_e ? step_up(edit_m, TOP_M) : step_dn(edit_m, TOP_M);
                        default: edit_s_n = inc_e ? step_up(edit_s, TOP_S) : step_dn(edit_s, TOP_S);
                    endcase
                end
            end
        endcase
    end

    assign bus.set     = set_q;
    assign bus.set_h   = set_h_q;
    assign bus.set_m   = set_m_q;
    assign bus.set_s   = set_s_q;
    assign bus.field   = state;
    assign bus.editing = (state != IDLE);
    assign dbg_state   = state;

endmodule

// File: tb/tb_clock_hms_setter.sv
// Directed bench for clock_hms_setter. The model below tracks the edit in
// plain integers: a current field number and a three-entry value array
// stepped with modulo arithmetic. A compare process checks every output on
// every falling edge, and a queue of hand-computed commits is drained by the
// observed `set` strobes.
module tb_clock_hms_setter;
  localparam int MH = 12;
  localparam int MM = 23;
  localparam int MS = 41;

  localparam logic [3:0] K_MODE = 4'b0001;
  localparam logic [3:0] K_INC  = 4'b0010;
  localparam logic [3:0] K_DEC  = 4'b0100;
  localparam logic [3:0] K_CAN  = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] dbg_state;

  clock_hms_setter_if bus ();

  clock_hms_setter #(.max_h(MH), .max_m(MM), .max_s(MS)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [17:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int   m_field;          // 0 = not editing, else 1..3 = field being edited
  int   m_val[1:3];
  int   m_out[1:3];
  int   mods[1:3] = '{MH, MM, MS};
  bit   m_set;
  bit [3:0] m_prev;

  function automatic void m_reset();
    m_field = 0;
    m_val   = '{0, 0, 0};
    m_out   = '{0, 0, 0};
    m_set   = 1'b0;
    m_prev  = 4'b1111;
  endfunction

  function automatic int clamp(input int v, input int lim);
    return (v < lim) ? v : 0;
  endfunction

  function automatic void m_step();
    bit [3:0] k, e;
    k = {bus.key_cancel, bus.key_dec, bus.key_inc, bus.key_mode};
    e = k & ~m_prev;
    m_prev = k;
    m_set = 1'b0;
    if (m_field == 0) begin
      if (e[0]) begin
        m_field  = 1;
        m_val[1] = clamp(int'(bus.cur_h), MH);
        m_val[2] = clamp(int'(bus.cur_m), MM);
        m_val[3] = clamp(int'(bus.cur_s), MS);
      end
    end else if (e[3]) begin
      m_field = 0;
    end else if (e[0]) begin
      if (m_field == 3) begin
        m_set   = 1'b1;
        m_out   = m_val;
        m_field = 0;
      end else begin
        m_field = m_field + 1;
      end
    end else if (e[1] && !e[2]) begin
      m_val[m_field] = (m_val[m_field] + 1) % mods[m_field];
    end else if (e[2] && !e[1]) begin
      m_val[m_field] = (m_val[m_field] + mods[m_field] - 1) % mods[m_field];
    end
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // ---------------- compare + scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("set", int'(bus.set), int'(m_set));
      chk("set_h", int'(bus.set_h), m_out[1]);
      chk("set_m", int'(bus.set_m), m_out[2]);
      chk("set_s", int'(bus.set_s), m_out[3]);
      chk("field", int'(bus.field), m_field);
      chk("editing", int'(bus.editing), int'(m_field != 0));
      chk("dbg_state", int'(dbg_state), m_field);
      if (bus.set) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_set", 1, 0);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          chk("commit_value", int'({bus.set_h, bus.set_m, bus.set_s}), int'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] k);
    bus.key_mode   = k[0];
    bus.key_inc    = k[1];
    bus.key_dec    = k[2];
    bus.key_cancel = k[3];
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    bus.cur_h = 6'(h);
    bus.cur_m = 6'(m);
    bus.cur_s = 6'(s);
  endtask

  // Keys go high 1 time unit after a rising edge and stay high for `hold`
  // edges. The task returns 1 time unit after the last of those edges.
  task automatic press(input logic [3:0] k, input int hold);
    @(posedge clk); #1;
    drive(k);
    repeat (hold) @(posedge clk);
    #1;
    drive(4'b0000);
  endtask

  task automatic expect_commit(input int h, input int m, input int s);
    exp_q.push_back({6'(h), 6'(m), 6'(s)});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    drive(4'b1111);
    set_cur(0, 0, 0);
    #1 rst_n = 1'b0;
    #2;
    chk("rst_set", int'(bus.set), 0);
    chk("rst_field", int'(bus.field), 0);
    chk("rst_set_h", int'(bus.set_h), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("held_through_reset_editing", int'(bus.editing), 0);
    chk("held_through_reset_field", int'(bus.field), 0);
    drive(4'b0000);
    repeat (2) @(posedge clk);

    // Edit and commit: 5:10:20 -> 7:9:20
    set_cur(5, 10, 20);
    press(K_MODE, 1);  chk("t1_field_h", int'(bus.field), 1);
    press(K_INC, 1);
    press(K_INC, 1);
    press(K_MODE, 1);  chk("t1_field_m", int'(bus.field), 2);
    press(K_DEC, 1);
    press(K_MODE, 1);  chk("t1_field_s", int'(bus.field), 3);
    expect_commit(7, 9, 20);
    press(K_MODE, 1);
    chk("t1_set", int'(bus.set), 1);
    chk("t1_set_h", int'(bus.set_h), 7);
    chk("t1_set_m", int'(bus.set_m), 9);
    chk("t1_set_s", int'(bus.set_s), 20);
    chk("t1_model_pin", m_out[1] * 10000 + m_out[2] * 100 + m_out[3], 70920);
    chk("t1_field_idle", int'(bus.field), 0);
    @(posedge clk); #1;
    chk("t1_set_drop", int'(bus.set), 0);
    chk("t1_set_h_hold", int'(bus.set_h), 7);

    // Cancel: values from the last commit must survive
    set_cur(3, 4, 5);
    press(K_MODE, 1);
    press(K_INC, 1);
    press(K_MODE, 1);
    press(K_CAN, 1);
    chk("t2_editing", int'(bus.editing), 0);
    repeat (3) @(posedge clk); #1;
    chk("t2_set", int'(bus.set), 0);
    chk("t2_set_h", int'(bus.set_h), 7);
    chk("t2_set_m", int'(bus.set_m), 9);
    chk("t2_set_s", int'(bus.set_s), 20);

    // Wrap-around: 11:0:40 -> 0:22:0
    set_cur(11, 0, 40);
    press(K_MODE, 1);
    press(K_INC, 1);
    press(K_MODE, 1);
    press(K_DEC, 1);
    press(K_MODE, 1);
    press(K_INC, 1);
    expect_commit(0, 22, 0);
    press(K_MODE, 1);
    chk("t3_set", int'(bus.set), 1);
    chk("t3_set_h", int'(bus.set_h), 0);
    chk("t3_set_m", int'(bus.set_m), 22);
    chk("t3_set_s", int'(bus.set_s), 0);

    // Held inc counts once, inc+dec together do nothing: 2:3:4 -> 3:3:4
    set_cur(2, 3, 4);
    press(K_MODE, 1);
    press(K_INC, 6);
    press(K_INC | K_DEC, 1);
    chk("t4_field_h", int'(bus.field), 1);
    press(K_MODE, 1);
    press(K_MODE, 1);
    expect_commit(3, 3, 4);
    press(K_MODE, 1);
    chk("t4_set", int'(bus.set), 1);
    chk("t4_set_h", int'(bus.set_h), 3);
    chk("t4_set_m", int'(bus.set_m), 3);

    // Cancel together with mode in EDIT_S: cancel wins, no commit
    set_cur(9, 9, 9);
    press(K_MODE, 1);
    press(K_MODE, 1);
    press(K_MODE, 1);
    chk("t5_field_s", int'(bus.field), 3);
    press(K_CAN | K_MODE, 1);
    chk("t5_set", int'(bus.set), 0);
    chk("t5_field", int'(bus.field), 0);
    chk("t5_set_h_hold", int'(bus.set_h), 3);

    // Snapshot clamp: hour 13 is out of range and loads 0 -> 0:5:6
    set_cur(13, 5, 6);
    press(K_MODE, 1);
    press(K_MODE, 1);
    press(K_MODE, 1);
    expect_commit(0, 5, 6);
    press(K_MODE, 1);
    chk("t6_set", int'(bus.set), 1);
    chk("t6_set_h", int'(bus.set_h), 0);
    chk("t6_set_s", int'(bus.set_s), 6);

    // Reset in EDIT_M: everything returns to 0 at once, with no strobe
    set_cur(1, 2, 3);
    press(K_MODE, 1);
    press(K_MODE, 1);
    chk("t7_field_m", int'(bus.field), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("t7_set", int'(bus.set), 0);
    chk("t7_field", int'(bus.field), 0);
    chk("t7_editing", int'(bus.editing), 0);
    chk("t7_set_h", int'(bus.set_h), 0);
    chk("t7_set_m", int'(bus.set_m), 0);
    chk("t7_set_s", int'(bus.set_s), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t7_after_set", int'(bus.set), 0);
    chk("t7_after_editing", int'(bus.editing), 0);

    chk("pending_commits", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
